// File: rtl/sample_buffer_writer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sample_buffer_writer: streams samples into the circular RAM buffer and    |
// | publishes the committed write pointer; optional macro                    |
// | SAMPLE_BUFFER_WRITER_DROP_COUNT_EN adds a saturating drop counter.       |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module sample_buffer_writer #(
   parameter int ADDR_W           = 9,
   parameter int DATA_W           = 24,
   parameter int STOP_ON_OVERFLOW = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              capture_en,
   input  logic              clear_ovf,
   input  logic [DATA_W-1:0] sample_in,
   input  logic              sample_valid,
   output logic              sample_ready,
   input  logic [ADDR_W-1:0] r_addr,
   output logic [ADDR_W-1:0] mem_waddr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_we,
   output logic [ADDR_W-1:0] w_addr,
   output logic              overflow,
`ifdef SAMPLE_BUFFER_WRITER_DROP_COUNT_EN
   output logic [15:0]       drop_count,
`endif
   output logic [1:0]        state_o
);

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_RUN      = 2'd1,
      ST_OVERFLOW = 2'd2
   } state_t;

   localparam logic c_stop = (STOP_ON_OVERFLOW != 0);

   state_t            r_state;
   logic [ADDR_W-1:0] r_wp;
   logic [ADDR_W-1:0] w_wp_next;
   logic              w_full;
   logic              w_accept;
   logic              w_drop;

   // One slot is always left empty so that wp == r_addr unambiguously means empty.
   assign w_wp_next    = r_wp + 1'b1;
   assign w_full       = (w_wp_next == r_addr);
   assign sample_ready = (r_state == ST_RUN) && !w_full;
   assign w_accept     = sample_valid && sample_ready;
   assign w_drop       = (r_state == ST_RUN) && sample_valid && w_full;
   assign state_o      = r_state;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= ST_IDLE;
         r_wp      <= '0;
         w_addr    <= '0;
         mem_we    <= 1'b0;
         mem_waddr <= '0;
         mem_wdata <= '0;
         overflow  <= 1'b0;
      end else begin
         mem_we <= w_accept;
         if (w_accept) begin
            mem_waddr <= r_wp;
            mem_wdata <= sample_in;
            r_wp      <= w_wp_next;
         end
         // Trails wp by one cycle so the reader only sees addresses already in RAM.
         w_addr <= r_wp;

         if (w_drop)
            overflow <= 1'b1;
         else if (clear_ovf)
            overflow <= 1'b0;

         case (r_state)
            ST_IDLE: begin
               if (capture_en)
                  r_state <= ST_RUN;
            end
            ST_RUN: begin
               if (w_drop && c_stop)
                  r_state <= ST_OVERFLOW;
               else if (!capture_en)
                  r_state <= ST_IDLE;
            end
            ST_OVERFLOW: begin
               if (clear_ovf)
                  r_state <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

`ifdef SAMPLE_BUFFER_WRITER_DROP_COUNT_EN
   localparam logic [15:0] c_drop_sat = 16'hFFFF;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         drop_count <= '0;
      end else if (w_drop) begin
         if (clear_ovf)
            drop_count <= 16'd1;
         else if (drop_count != c_drop_sat)
            drop_count <= drop_count + 16'd1;
      end else if (clear_ovf) begin
         drop_count <= '0;
      end
   end
`endif

endmodule
`default_nettype wire

// File: tb/tb_sample_buffer_writer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_sample_buffer_writer: directed vectors plus corner sequences.         |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_sample_buffer_writer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cap = 1'b0, clr = 1'b0, vld = 1'b0;
   logic [23:0] din = '0;
   logic [8:0]  raddr = '0;
   logic        rdy, we, ovf;
   logic [8:0]  waddr, wa;
   logic [23:0] wdata;
   logic [1:0]  st;

   // Second instance: small buffer, stop-on-overflow behaviour.
   logic        s_cap = 1'b0, s_clr = 1'b0, s_vld = 1'b0;
   logic [23:0] s_din = '0;
   logic [2:0]  s_raddr = '0;
   logic        s_rdy, s_we, s_ovf;
   logic [2:0]  s_waddr, s_wa;
   logic [23:0] s_wdata;
   logic [1:0]  s_st;
`ifdef SAMPLE_BUFFER_WRITER_DROP_COUNT_EN
   logic [15:0] dcnt, s_dcnt;
`endif

   int total = 0;
   int passed = 0;

   always #5 clk = ~clk;

   sample_buffer_writer #(.ADDR_W(9), .DATA_W(24), .STOP_ON_OVERFLOW(0)) u_dut (
      .clk(clk), .rst(rst), .capture_en(cap), .clear_ovf(clr),
      .sample_in(din), .sample_valid(vld), .sample_ready(rdy), .r_addr(raddr),
      .mem_waddr(waddr), .mem_wdata(wdata), .mem_we(we), .w_addr(wa),
      .overflow(ovf),
`ifdef SAMPLE_BUFFER_WRITER_DROP_COUNT_EN
      .drop_count(dcnt),
`endif
      .state_o(st)
   );

   sample_buffer_writer #(.ADDR_W(3), .DATA_W(24), .STOP_ON_OVERFLOW(1)) u_stop (
      .clk(clk), .rst(rst), .capture_en(s_cap), .clear_ovf(s_clr),
      .sample_in(s_din), .sample_valid(s_vld), .sample_ready(s_rdy), .r_addr(s_raddr),
      .mem_waddr(s_waddr), .mem_wdata(s_wdata), .mem_we(s_we), .w_addr(s_wa),
      .overflow(s_ovf),
`ifdef SAMPLE_BUFFER_WRITER_DROP_COUNT_EN
      .drop_count(s_dcnt),
`endif
      .state_o(s_st)
   );

   typedef struct {
      logic        cap, clr, vld;
      logic [23:0] data;
      logic [8:0]  raddr;
      logic        e_rdy, e_we;
      logic [8:0]  e_waddr;
      logic [23:0] e_wdata;
      logic [8:0]  e_wa;
      logic        e_ovf;
      logic [1:0]  e_st;
   } vec_t;

   vec_t vecs[11];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp)
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      else
         passed++;
   endtask

   initial begin
      int          errs;
      int          acc;
      int          wp_m;
      logic        exp_acc;
      logic [8:0]  wrap_exp [3];

      //         cap clr vld data        raddr rdy we waddr wdata       wa   ovf st
      vecs[0]  = '{1'b1, 1'b0, 1'b0, 24'h000000, 9'd0,  1'b0, 1'b0, 9'd0, 24'h000000, 9'd0, 1'b0, 2'd1};
      vecs[1]  = '{1'b1, 1'b0, 1'b1, 24'hA5C3E1, 9'd0,  1'b1, 1'b1, 9'd0, 24'hA5C3E1, 9'd0, 1'b0, 2'd1};
      vecs[2]  = '{1'b1, 1'b0, 1'b1, 24'h123456, 9'd0,  1'b1, 1'b1, 9'd1, 24'h123456, 9'd1, 1'b0, 2'd1};
      vecs[3]  = '{1'b1, 1'b0, 1'b0, 24'h000000, 9'd0,  1'b1, 1'b0, 9'd1, 24'h123456, 9'd2, 1'b0, 2'd1};
      vecs[4]  = '{1'b1, 1'b0, 1'b1, 24'hFFFFFF, 9'd3,  1'b0, 1'b0, 9'd1, 24'h123456, 9'd2, 1'b1, 2'd1};
      vecs[5]  = '{1'b1, 1'b0, 1'b1, 24'h000001, 9'd4,  1'b1, 1'b1, 9'd2, 24'h000001, 9'd2, 1'b1, 2'd1};
      vecs[6]  = '{1'b1, 1'b1, 1'b0, 24'h000000, 9'd4,  1'b0, 1'b0, 9'd2, 24'h000001, 9'd3, 1'b0, 2'd1};
      vecs[7]  = '{1'b0, 1'b0, 1'b1, 24'h0ABCDE, 9'd10, 1'b1, 1'b1, 9'd3, 24'h0ABCDE, 9'd3, 1'b0, 2'd0};
      vecs[8]  = '{1'b0, 1'b0, 1'b1, 24'h111111, 9'd10, 1'b0, 1'b0, 9'd3, 24'h0ABCDE, 9'd4, 1'b0, 2'd0};
      vecs[9]  = '{1'b1, 1'b0, 1'b0, 24'h000000, 9'd5,  1'b0, 1'b0, 9'd3, 24'h0ABCDE, 9'd4, 1'b0, 2'd1};
      vecs[10] = '{1'b1, 1'b1, 1'b1, 24'h555555, 9'd5,  1'b0, 1'b0, 9'd3, 24'h0ABCDE, 9'd4, 1'b1, 2'd1};
      wrap_exp[0] = 9'd510;
      wrap_exp[1] = 9'd511;
      wrap_exp[2] = 9'd0;

      // Reset state
      #2;
      chk("rst_state", st, 2'd0);
      chk("rst_we", we, 1'b0);
      chk("rst_wa", wa, 9'd0);
      chk("rst_ovf", ovf, 1'b0);
      chk("rst_rdy", rdy, 1'b0);
      tick();
      rst = 1'b0;

      for (int i = 0; i < 11; i++) begin
         cap = vecs[i].cap; clr = vecs[i].clr; vld = vecs[i].vld;
         din = vecs[i].data; raddr = vecs[i].raddr;
         #1;
         chk($sformatf("v%0d_rdy", i), rdy, vecs[i].e_rdy);
         tick();
         chk($sformatf("v%0d_we", i), we, vecs[i].e_we);
         chk($sformatf("v%0d_waddr", i), waddr, vecs[i].e_waddr);
         chk($sformatf("v%0d_wdata", i), wdata, vecs[i].e_wdata);
         chk($sformatf("v%0d_waddr_pub", i), wa, vecs[i].e_wa);
         chk($sformatf("v%0d_ovf", i), ovf, vecs[i].e_ovf);
         chk($sformatf("v%0d_state", i), st, vecs[i].e_st);
      end
      clr = 1'b0;
`ifdef SAMPLE_BUFFER_WRITER_DROP_COUNT_EN
      chk("vec_drop_count", dcnt, 16'd1);
`endif

      // Reset asserted mid-write must clear outputs without a clock edge
      raddr = 9'd0; vld = 1'b1; din = 24'h777777;
      tick();
      chk("midrst_pre_we", we, 1'b1);
      #2;
      rst = 1'b1;
      #1;
      chk("midrst_we", we, 1'b0);
      chk("midrst_wa", wa, 9'd0);
      chk("midrst_state", st, 2'd0);
      chk("midrst_waddr", waddr, 9'd0);
      chk("midrst_wdata", wdata, 24'd0);
      tick();
      rst = 1'b0;

      // Burst to full: 520 samples, reader parked at 0
      vld = 1'b0; cap = 1'b1; raddr = 9'd0;
      tick();
      errs = 0; acc = 0; wp_m = 0;
      for (int i = 0; i < 520; i++) begin
         vld = 1'b1; din = 24'(i);
         #1;
         exp_acc = (((wp_m + 1) % 512) != 0);
         if (rdy !== exp_acc) errs++;
         tick();
         if (exp_acc) begin
            if (we !== 1'b1 || waddr !== 9'(wp_m) || wdata !== 24'(i)) errs++;
            wp_m++;
            acc++;
         end else if (we !== 1'b0) begin
            errs++;
         end
      end
      chk("burst_beats", errs, 0);
      chk("burst_accepts", acc, 511);
      chk("burst_ovf", ovf, 1'b1);
      chk("burst_rdy_full", rdy, 1'b0);
      vld = 1'b0;
      tick();
      chk("burst_wa", wa, 9'd511);
`ifdef SAMPLE_BUFFER_WRITER_DROP_COUNT_EN
      chk("burst_drop_count", dcnt, 16'd9);
`endif

      // Wrap: wp=510, reader at 100, three samples
      rst = 1'b1;
      tick();
      rst = 1'b0; cap = 1'b1; raddr = 9'd0;
      tick();
      vld = 1'b1;
      repeat (510) tick();
      raddr = 9'd100;
      for (int k = 0; k < 3; k++) begin
         din = 24'h000100 + 24'(k);
         tick();
         chk($sformatf("wrap_waddr%0d", k), waddr, wrap_exp[k]);
      end
      vld = 1'b0;
      tick();
      tick();
      chk("wrap_wa", wa, 9'd1);
      chk("wrap_ovf", ovf, 1'b0);

      // Stop-on-overflow instance
      cap = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0; s_cap = 1'b1; s_raddr = 3'd0;
      tick();
      s_vld = 1'b1;
      repeat (7) tick();
      chk("stop_pre_state", s_st, 2'd1);
      tick();
      chk("stop_state", s_st, 2'd2);
      chk("stop_ovf", s_ovf, 1'b1);
      s_raddr = 3'd3;
      #1;
      chk("stop_rdy", s_rdy, 1'b0);
      tick();
      chk("stop_we", s_we, 1'b0);
      chk("stop_hold", s_st, 2'd2);
      s_vld = 1'b0; s_cap = 1'b0; s_clr = 1'b1;
      tick();
      chk("stop_clr_state", s_st, 2'd0);
      chk("stop_clr_ovf", s_ovf, 1'b0);
      s_clr = 1'b0; s_cap = 1'b1;
      tick();
      chk("stop_rerun", s_st, 2'd1);
      chk("stop_rerun_rdy", s_rdy, 1'b1);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
`default_nettype wire
